// File: rtl/sid_bus_regs.sv
// Bus-side register file for a SID-style sound chip: write-only voice and filter
// fields, readback of the analogue sources, and a decaying data-bus latch.
module sid_bus_regs #(
  parameter int unsigned BUS_DECAY = 8191
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        clk_en,
  input  logic        cs_n,
  input  logic        rw,
  input  logic [4:0]  addr,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3,
  input  logic [7:0]  potx,
  input  logic [7:0]  poty,
  output logic [15:0] r_freq     [0:2],
  output logic [11:0] r_pw       [0:2],
  output logic        r_noise    [0:2],
  output logic        r_pulse    [0:2],
  output logic        r_saw      [0:2],
  output logic        r_triangle [0:2],
  output logic        r_test     [0:2],
  output logic        r_ring     [0:2],
  output logic        r_sync     [0:2],
  output logic        r_gate     [0:2],
  output logic [3:0]  r_atk      [0:2],
  output logic [3:0]  r_dcy      [0:2],
  output logic [3:0]  r_stn      [0:2],
  output logic [3:0]  r_rls      [0:2],
  output logic [10:0] f_fc,
  output logic [3:0]  f_res,
  output logic [3:0]  f_filt,
  output logic [3:0]  f_mode,
  output logic [3:0]  f_vol
);

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_MIN = 13;
  localparam int unsigned CNT_W   = ($clog2(BUS_DECAY + 1) > CNT_MIN) ?
                                    $clog2(BUS_DECAY + 1) : CNT_MIN;
  localparam int NUM_VOICES   = 3;
  localparam int VOICE_STRIDE = 7;

  logic              wr_c;
  logic              rd_c;
  logic              src_hit_c;
  logic              load_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] latch;
  logic [CNT_W-1:0]  cnt;

  // Access decode and read-data mux; unmapped reads return the pre-update latch.
  always_comb begin
    wr_c      = clk_en & ~cs_n & ~rw;
    rd_c      = clk_en & ~cs_n & rw;
    src_hit_c = 1'b1;
    rd_data_c = latch;
    case (addr)
      5'h19:   rd_data_c = potx;
      5'h1A:   rd_data_c = poty;
      5'h1B:   rd_data_c = osc3;
      5'h1C:   rd_data_c = env3;
      default: src_hit_c = 1'b0;
    endcase
    load_c      = wr_c | (rd_c & src_hit_c);
    load_data_c = wr_c ? d_in : rd_data_c;
  end

  // Bus latch with decay; a load on the expiry tick takes priority over the clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      latch <= '0;
      cnt   <= '0;
    end else if (load_c) begin
      latch <= load_data_c;
      cnt   <= CNT_W'(BUS_DECAY);
    end else if (clk_en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        latch <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      d_out <= '0;
    end else if (rd_c) begin
      d_out <= rd_data_c;
    end
  end

  // Per-voice fields at base 7*v.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_freq[v]     <= '0;
        r_pw[v]       <= '0;
        r_noise[v]    <= 1'b0;
        r_pulse[v]    <= 1'b0;
        r_saw[v]      <= 1'b0;
        r_triangle[v] <= 1'b0;
        r_test[v]     <= 1'b0;
        r_ring[v]     <= 1'b0;
        r_sync[v]     <= 1'b0;
        r_gate[v]     <= 1'b0;
        r_atk[v]      <= '0;
        r_dcy[v]      <= '0;
        r_stn[v]      <= '0;
        r_rls[v]      <= '0;
      end
    end else if (wr_c) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (addr == ADDR_W'(VOICE_STRIDE * v)) begin
          r_freq[v][7:0] <= d_in;
        end
        if (addr == ADDR_W'(VOICE_STRIDE * v + 1)) begin
          r_freq[v][15:8] <= d_in;
        end
        if (addr == ADDR_W'(VOICE_STRIDE * v + 2)) begin
          r_pw[v][7:0] <= d_in;
        end
        if (addr == ADDR_W'(VOICE_STRIDE * v + 3)) begin
          r_pw[v][11:8] <= d_in[3:0];
        end
        if (addr == ADDR_W'(VOICE_STRIDE * v + 4)) begin
          r_noise[v]    <= d_in[7];
          r_pulse[v]    <= d_in[6];
          r_saw[v]      <= d_in[5];
          r_triangle[v] <= d_in[4];
          r_test[v]     <= d_in[3];
          r_ring[v]     <= d_in[2];
          r_sync[v]     <= d_in[1];
          r_gate[v]     <= d_in[0];
        end
        if (addr == ADDR_W'(VOICE_STRIDE * v + 5)) begin
          r_atk[v] <= d_in[7:4];
          r_dcy[v] <= d_in[3:0];
        end
        if (addr == ADDR_W'(VOICE_STRIDE * v + 6)) begin
          r_stn[v] <= d_in[7:4];
          r_rls[v] <= d_in[3:0];
        end
      end
    end
  end

  // Filter and volume fields.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      f_fc   <= '0;
      f_res  <= '0;
      f_filt <= '0;
      f_mode <= '0;
      f_vol  <= '0;
    end else if (wr_c) begin
      case (addr)
        5'h15:   f_fc[2:0]  <= d_in[2:0];
        5'h16:   f_fc[10:3] <= d_in;
        5'h17: begin
          f_res  <= d_in[7:4];
          f_filt <= d_in[3:0];
        end
        5'h18: begin
          f_mode <= d_in[7:4];
          f_vol  <= d_in[3:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_bus_regs.sv
// Scoreboarded bench for sid_bus_regs: a register-image model with a
// timestamped bus latch predicts every output after each clock edge.
module tb_sid_bus_regs;

  localparam int unsigned D = 8191;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        clk_en;
  logic        cs_n;
  logic        rw;
  logic [4:0]  addr;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [7:0]  osc3, env3, potx, poty;
  logic [15:0] r_freq     [0:2];
  logic [11:0] r_pw       [0:2];
  logic        r_noise    [0:2];
  logic        r_pulse    [0:2];
  logic        r_saw      [0:2];
  logic        r_triangle [0:2];
  logic        r_test     [0:2];
  logic        r_ring     [0:2];
  logic        r_sync     [0:2];
  logic        r_gate     [0:2];
  logic [3:0]  r_atk      [0:2];
  logic [3:0]  r_dcy      [0:2];
  logic [3:0]  r_stn      [0:2];
  logic [3:0]  r_rls      [0:2];
  logic [10:0] f_fc;
  logic [3:0]  f_res, f_filt, f_mode, f_vol;

  sid_bus_regs #(.BUS_DECAY(D)) dut (
    .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .cs_n(cs_n), .rw(rw),
    .addr(addr), .d_in(d_in), .d_out(d_out),
    .osc3(osc3), .env3(env3), .potx(potx), .poty(poty),
    .r_freq(r_freq), .r_pw(r_pw), .r_noise(r_noise), .r_pulse(r_pulse),
    .r_saw(r_saw), .r_triangle(r_triangle), .r_test(r_test), .r_ring(r_ring),
    .r_sync(r_sync), .r_gate(r_gate), .r_atk(r_atk), .r_dcy(r_dcy),
    .r_stn(r_stn), .r_rls(r_rls),
    .f_fc(f_fc), .f_res(f_res), .f_filt(f_filt), .f_mode(f_mode), .f_vol(f_vol)
  );

  always #5 clk = ~clk;

  typedef logic [190:0] snap_t;

  int n_checks = 0;
  int n_pass   = 0;
  snap_t exp_q[$];

  // Reference model: register image written by address, plus latch timestamps.
  logic [7:0] regs [0:31];
  logic [7:0] m_dout;
  logic [7:0] lat_val;
  longint     tick;
  longint     load_tick;
  logic [7:0] s_osc3 = '0, s_env3 = '0, s_potx = '0, s_poty = '0;

  task automatic check(input string name, input snap_t act, input snap_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    m_dout    = '0;
    lat_val   = '0;
    tick      = 0;
    load_tick = 0;
  endtask

  // A loaded value stays visible for D ticks after its load tick, inclusive.
  function automatic logic [7:0] latch_now();
    return ((tick - load_tick) <= longint'(D)) ? lat_val : 8'h00;
  endfunction

  function automatic logic [51:0] model_voice(input int v);
    int b;
    b = 7 * v;
    return {regs[b+1], regs[b], regs[b+3][3:0], regs[b+2], regs[b+4], regs[b+5], regs[b+6]};
  endfunction

  function automatic snap_t model_snap();
    return {model_voice(0), model_voice(1), model_voice(2),
            regs[5'h16], regs[5'h15][2:0], regs[5'h17], regs[5'h18], m_dout};
  endfunction

  function automatic logic [51:0] dut_voice(input int v);
    return {r_freq[v], r_pw[v], r_noise[v], r_pulse[v], r_saw[v], r_triangle[v],
            r_test[v], r_ring[v], r_sync[v], r_gate[v], r_atk[v], r_dcy[v], r_stn[v], r_rls[v]};
  endfunction

  function automatic snap_t dut_snap();
    return {dut_voice(0), dut_voice(1), dut_voice(2), f_fc, f_res, f_filt, f_mode, f_vol, d_out};
  endfunction

  // Drive one cycle at the falling edge, advance the model, queue the expectation.
  task automatic step(input logic ce, input logic cs, input logic r,
                      input logic [4:0] a, input logic [7:0] din);
    logic [7:0] v;
    logic       hit;
    @(negedge clk);
    clk_en = ce; cs_n = cs; rw = r; addr = a; d_in = din;
    osc3 = s_osc3; env3 = s_env3; potx = s_potx; poty = s_poty;
    if (n_reset) begin
      if (ce && !cs) begin
        if (!r) begin
          regs[a]   = din;
          lat_val   = din;
          load_tick = tick;
        end else begin
          hit = 1'b1;
          case (a)
            5'h19:   v = s_potx;
            5'h1A:   v = s_poty;
            5'h1B:   v = s_osc3;
            5'h1C:   v = s_env3;
            default: begin v = latch_now(); hit = 1'b0; end
          endcase
          m_dout = v;
          if (hit) begin
            lat_val   = v;
            load_tick = tick;
          end
        end
      end
      if (ce) tick++;
    end
    exp_q.push_back(model_snap());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every output just after each edge against the queued prediction.
  always @(posedge clk) begin
    snap_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("snapshot", dut_snap(), e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a;
    logic       ce, cs, r;

    n_reset = 1'b0; clk_en = 1'b0; cs_n = 1'b1; rw = 1'b1; addr = '0; d_in = '0;
    osc3 = '0; env3 = '0; potx = '0; poty = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", dut_snap(), '0);
    @(negedge clk);
    n_reset = 1'b1;

    // Voice 0 frequency and control.
    step(1, 0, 0, 5'h00, 8'h34);
    step(1, 0, 0, 5'h01, 8'h12);
    step(1, 0, 0, 5'h04, 8'h41);
    settle();
    check("v0_freq", r_freq[0], 16'h1234);
    check("v0_ctrl", {r_noise[0], r_pulse[0], r_saw[0], r_triangle[0],
                      r_test[0], r_ring[0], r_sync[0], r_gate[0]}, 8'h41);
    check("v12_idle", {dut_voice(1), dut_voice(2)}, '0);

    // Filter.
    step(1, 0, 0, 5'h15, 8'hFF);
    step(1, 0, 0, 5'h16, 8'hAB);
    step(1, 0, 0, 5'h18, 8'h9F);
    settle();
    check("f_fc", f_fc, 11'h55F);
    check("f_mode_vol", {f_mode, f_vol}, 8'h9F);

    // Latch readback and decay.
    step(1, 0, 0, 5'h0A, 8'h5A);
    step(1, 0, 1, 5'h0A, 8'h00);
    settle();
    check("latch_read", d_out, 8'h5A);
    for (int k = 2; k <= int'(D); k++) step(1, 0, 1, 5'h00, 8'h00);
    settle();
    check("latch_last_tick", d_out, 8'h5A);
    step(1, 0, 1, 5'h00, 8'h00);
    settle();
    check("latch_decayed", d_out, 8'h00);

    // OSC3 readback refreshes the latch.
    s_osc3 = 8'h77;
    step(1, 0, 1, 5'h1B, 8'h00);
    settle();
    check("osc3_read", d_out, 8'h77);
    s_osc3 = 8'h00;
    step(1, 0, 1, 5'h05, 8'h00);
    settle();
    check("osc3_latched", d_out, 8'h77);

    // Write lands on the expiry tick: load wins and decay restarts.
    step(1, 0, 0, 5'h03, 8'h11);
    for (int k = 1; k < int'(D); k++) step(1, 0, 1, 5'h00, 8'h00);
    step(1, 0, 0, 5'h1F, 8'hC3);
    for (int k = 1; k <= int'(D); k++) step(1, 0, 1, 5'h00, 8'h00);
    settle();
    check("expiry_load_kept", d_out, 8'hC3);
    step(1, 0, 1, 5'h00, 8'h00);
    settle();
    check("expiry_reload_decays", d_out, 8'h00);

    // Deselected ticks change nothing; a write then re-establishes the latch.
    step(1, 0, 0, 5'h1D, 8'h3C);
    for (int k = 0; k < 6; k++) step(1, 1, 1'($urandom), 5'($urandom), 8'($urandom));
    step(1, 0, 0, 5'h1F, 8'($urandom));
    step(1, 0, 1, 5'h1E, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s_osc3 = 8'($urandom); s_env3 = 8'($urandom);
      s_potx = 8'($urandom); s_poty = 8'($urandom);
      ce = ($urandom_range(0, 3) != 0);
      cs = ce ? 1'b0 : 1'($urandom);
      r  = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 5'(25 + $urandom_range(0, 3)) : 5'($urandom);
      step(ce, cs, r, a, 8'($urandom));
    end

    // clk_en low with a pending write, then asynchronous reset mid-access.
    for (int k = 0; k < 10; k++) step(0, 0, 0, 5'h0B, 8'hFF);
    settle();
    check("ce_low_hold", dut_snap(), model_snap());
    clk_en = 1'b1;
    #2;
    n_reset = 1'b0;
    #1;
    check("async_reset", dut_snap(), '0);
    model_reset();
    step(1, 0, 0, 5'h0B, 8'hFF);
    step(1, 0, 0, 5'h0B, 8'hFF);
    @(posedge clk);
    #2;
    n_reset = 1'b1;
    check("abort_write", dut_voice(1), '0);
    step(1, 0, 0, 5'h0C, 8'h5F);
    step(1, 0, 1, 5'h0C, 8'h00);
    settle();
    check("first_access", {r_atk[1], r_dcy[1], d_out}, 16'h5F5F);

    @(posedge clk);
    #3;
    check("queue_drained", snap_t'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
